// File: rtl/overlay_pkg.sv
// rtl/overlay_pkg.sv - shared FSM encoding, scale thresholds/codes and corner helpers for the overlay sequencer
package overlay_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_SQX,
    ST_SQY,
    ST_CLASS,
    ST_COMMIT
  } state_t;

  localparam logic [22:0] THR_SCALE4 = 23'd230400;
  localparam logic [22:0] THR_SCALE3 = 23'd102400;
  localparam logic [22:0] THR_SCALE2 = 23'd36864;
  localparam logic [22:0] THR_SCALE1 = 23'd100;

  localparam logic [3:0] SCALE_0     = 4'd0;
  localparam logic [3:0] SCALE_1     = 4'd1;
  localparam logic [3:0] SCALE_2     = 4'd2;
  localparam logic [3:0] SCALE_3     = 4'd3;
  localparam logic [3:0] SCALE_4     = 4'd4;
  localparam logic [3:0] SCALE_RESET = SCALE_2;

  typedef struct packed {
    logic [10:0] tl_x;
    logic [10:0] tl_y;
    logic [10:0] tr_x;
    logic [10:0] tr_y;
    logic [10:0] bl_x;
    logic [10:0] bl_y;
    logic [10:0] br_x;
    logic [10:0] br_y;
  } corners_t;

  // Midpoint in 12 bits so the carry is kept before the shift back to 11.
  function automatic logic [10:0] avg11(input logic [10:0] a, input logic [10:0] b);
    logic [11:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[11:1];
  endfunction

  function automatic corners_t smooth_corners(input corners_t cur, input corners_t nxt);
    corners_t r;
    r.tl_x = avg11(cur.tl_x, nxt.tl_x);
    r.tl_y = avg11(cur.tl_y, nxt.tl_y);
    r.tr_x = avg11(cur.tr_x, nxt.tr_x);
    r.tr_y = avg11(cur.tr_y, nxt.tr_y);
    r.bl_x = avg11(cur.bl_x, nxt.bl_x);
    r.bl_y = avg11(cur.bl_y, nxt.bl_y);
    r.br_x = avg11(cur.br_x, nxt.br_x);
    r.br_y = avg11(cur.br_y, nxt.br_y);
    return r;
  endfunction

endpackage

// File: rtl/scale_classify.sv
// rtl/scale_classify.sv - combinational squared-distance to scale-code classifier
module scale_classify
  import overlay_pkg::*;
(
  input  logic [22:0] dist_sq,
  output logic [3:0]  scale_code
);

  always_comb begin
    scale_code = SCALE_0;
    if (dist_sq >= THR_SCALE4)      scale_code = SCALE_4;
    else if (dist_sq >= THR_SCALE3) scale_code = SCALE_3;
    else if (dist_sq >= THR_SCALE2) scale_code = SCALE_2;
    else if (dist_sq >= THR_SCALE1) scale_code = SCALE_1;
  end

endmodule

// File: rtl/overlay_param_sequencer.sv
// rtl/overlay_param_sequencer.sv - frame-synchronous corner capture, scale classification and atomic commit
// Optional macro CORNER_SMOOTH_EN: commit averages new corners with the previously committed ones.
module overlay_param_sequencer
  import overlay_pkg::*;
#(
  parameter logic [10:0] p_capture_line = 11'd480,
  parameter logic [18:0] p_min_pixels   = 19'd200,
  parameter int          p_lost_frames  = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] VGA_X,
  input  logic [10:0] VGA_Y,
  input  logic [10:0] top_left_x,
  input  logic [10:0] top_left_y,
  input  logic [10:0] top_right_x,
  input  logic [10:0] top_right_y,
  input  logic [10:0] bot_left_x,
  input  logic [10:0] bot_left_y,
  input  logic [10:0] bot_right_x,
  input  logic [10:0] bot_right_y,
  input  logic [18:0] color_count,
  output logic [10:0] cmt_tl_x,
  output logic [10:0] cmt_tl_y,
  output logic [10:0] cmt_tr_x,
  output logic [10:0] cmt_tr_y,
  output logic [10:0] cmt_bl_x,
  output logic [10:0] cmt_bl_y,
  output logic [10:0] cmt_br_x,
  output logic [10:0] cmt_br_y,
  output logic [3:0]  scale,
  output logic        overlay_en,
  output logic        params_updated,
  output logic        busy
);

  localparam logic [2:0] LOST_MAX = 3'(p_lost_frames);

  state_t             state;
  corners_t           live;
  corners_t           sh;
  corners_t           cmt;
  logic [18:0]        sh_count;
  logic signed [11:0] dx;
  logic signed [11:0] dy;
  logic [22:0]        sq_acc;
  logic [3:0]         scale_next;
  logic [3:0]         class_code;
  logic [2:0]         lost_cnt;
  logic [2:0]         lost_inc;
  logic               trigger;
  logic signed [21:0] mul_op;
  logic [21:0]        sq_term;

  assign live = {top_left_x, top_left_y, top_right_x, top_right_y,
                 bot_left_x, bot_left_y, bot_right_x, bot_right_y};
  assign trigger  = (VGA_X == 11'd0) && (VGA_Y == p_capture_line);
  assign lost_inc = (lost_cnt == LOST_MAX) ? lost_cnt : lost_cnt + 3'd1;

  // One squarer shared between the x and y terms; the magnitude always fits in 22 bits.
  assign mul_op  = (state == ST_SQX) ? 22'(dx) : 22'(dy);
  assign sq_term = mul_op * mul_op;

  scale_classify u_classify (
    .dist_sq    (sq_acc),
    .scale_code (class_code)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      sh             <= '0;
      sh_count       <= '0;
      dx             <= '0;
      dy             <= '0;
      sq_acc         <= '0;
      scale_next     <= SCALE_RESET;
      cmt            <= '0;
      scale          <= SCALE_RESET;
      overlay_en     <= 1'b0;
      params_updated <= 1'b0;
      lost_cnt       <= '0;
    end else begin
      params_updated <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (trigger) begin
            sh       <= live;
            sh_count <= color_count;
            state    <= ST_LATCH;
          end
        end
        ST_LATCH: begin
          if (sh_count < p_min_pixels) begin
            lost_cnt <= lost_inc;
            if (lost_inc == LOST_MAX) overlay_en <= 1'b0;
            state <= ST_IDLE;
          end else begin
            dx    <= {1'b0, sh.tl_x} - {1'b0, sh.tr_x};
            dy    <= {1'b0, sh.tl_y} - {1'b0, sh.tr_y};
            state <= ST_SQX;
          end
        end
        ST_SQX: begin
          sq_acc <= {1'b0, sq_term};
          state  <= ST_SQY;
        end
        ST_SQY: begin
          sq_acc <= sq_acc + {1'b0, sq_term};
          state  <= ST_CLASS;
        end
        ST_CLASS: begin
          scale_next <= class_code;
          state      <= ST_COMMIT;
        end
        ST_COMMIT: begin
`ifdef CORNER_SMOOTH_EN
          // With the overlay off there is no trusted history, so load raw.
          cmt <= overlay_en ? smooth_corners(cmt, sh) : sh;
`else
          cmt <= sh;
`endif
          scale          <= scale_next;
          overlay_en     <= 1'b1;
          lost_cnt       <= '0;
          params_updated <= 1'b1;
          state          <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy     = (state != ST_IDLE);
  assign cmt_tl_x = cmt.tl_x;
  assign cmt_tl_y = cmt.tl_y;
  assign cmt_tr_x = cmt.tr_x;
  assign cmt_tr_y = cmt.tr_y;
  assign cmt_bl_x = cmt.bl_x;
  assign cmt_bl_y = cmt.bl_y;
  assign cmt_br_x = cmt.br_x;
  assign cmt_br_y = cmt.br_y;

endmodule

// File: tb/tb_overlay_param_sequencer.sv
// tb/tb_overlay_param_sequencer.sv - scoreboard bench for overlay_param_sequencer
module tb_overlay_param_sequencer;
  import overlay_pkg::*;

  typedef struct {
    corners_t   c;
    logic [3:0] sc;
  } want_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] VGA_X, VGA_Y;
  corners_t    live;
  logic [18:0] color_count;
  logic [10:0] cmt_tl_x, cmt_tl_y, cmt_tr_x, cmt_tr_y;
  logic [10:0] cmt_bl_x, cmt_bl_y, cmt_br_x, cmt_br_y;
  logic [3:0]  scale;
  logic        overlay_en, params_updated, busy;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  want_t sb[$];

  corners_t   m_c;
  logic [3:0] m_scale;
  bit         m_en;
  int         m_lost;

  always #5 clk = ~clk;

  overlay_param_sequencer dut (
    .clk(clk), .reset(reset), .VGA_X(VGA_X), .VGA_Y(VGA_Y),
    .top_left_x(live.tl_x), .top_left_y(live.tl_y),
    .top_right_x(live.tr_x), .top_right_y(live.tr_y),
    .bot_left_x(live.bl_x), .bot_left_y(live.bl_y),
    .bot_right_x(live.br_x), .bot_right_y(live.br_y),
    .color_count(color_count),
    .cmt_tl_x(cmt_tl_x), .cmt_tl_y(cmt_tl_y), .cmt_tr_x(cmt_tr_x), .cmt_tr_y(cmt_tr_y),
    .cmt_bl_x(cmt_bl_x), .cmt_bl_y(cmt_bl_y), .cmt_br_x(cmt_br_x), .cmt_br_y(cmt_br_y),
    .scale(scale), .overlay_en(overlay_en), .params_updated(params_updated), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    if (obs !== want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, obs, want);
    end
  endtask

  function automatic corners_t mk(input int a, b, c, d, e, f, g, h);
    corners_t r;
    r = {11'(a), 11'(b), 11'(c), 11'(d), 11'(e), 11'(f), 11'(g), 11'(h)};
    return r;
  endfunction

  function automatic logic [3:0] cls(input int d);
    if (d >= 230400) return 4'd4;
    if (d >= 102400) return 4'd3;
    if (d >= 36864)  return 4'd2;
    if (d >= 100)    return 4'd1;
    return 4'd0;
  endfunction

  function automatic logic [10:0] mid(input logic [10:0] a, input logic [10:0] b);
    int s;
    s = (int'(a) + int'(b)) / 2;
    return 11'(s);
  endfunction

  task automatic model_reset();
    m_c = '0; m_scale = 4'd2; m_en = 0; m_lost = 0;
  endtask

  task automatic model_frame(input corners_t c, input int cnt);
    want_t w;
    int dxv, dyv;
    if (cnt >= 200) begin
      dxv = int'(c.tl_x) - int'(c.tr_x);
      dyv = int'(c.tl_y) - int'(c.tr_y);
      w.sc = cls(dxv * dxv + dyv * dyv);
      w.c  = c;
`ifdef CORNER_SMOOTH_EN
      if (m_en) begin
        w.c.tl_x = mid(m_c.tl_x, c.tl_x); w.c.tl_y = mid(m_c.tl_y, c.tl_y);
        w.c.tr_x = mid(m_c.tr_x, c.tr_x); w.c.tr_y = mid(m_c.tr_y, c.tr_y);
        w.c.bl_x = mid(m_c.bl_x, c.bl_x); w.c.bl_y = mid(m_c.bl_y, c.bl_y);
        w.c.br_x = mid(m_c.br_x, c.br_x); w.c.br_y = mid(m_c.br_y, c.br_y);
      end
`endif
      m_c = w.c; m_scale = w.sc; m_en = 1; m_lost = 0;
      sb.push_back(w);
    end else begin
      if (m_lost < 3) m_lost++;
      if (m_lost == 3) m_en = 0;
    end
  endtask

  always @(negedge clk) begin : monitor
    want_t w;
    if (params_updated === 1'b1) begin
      pulses++;
      if (sb.size() == 0) check("unexpected_pulse", 1, 0);
      else begin
        w = sb.pop_front();
        check("cmt_tl_x", cmt_tl_x, w.c.tl_x); check("cmt_tl_y", cmt_tl_y, w.c.tl_y);
        check("cmt_tr_x", cmt_tr_x, w.c.tr_x); check("cmt_tr_y", cmt_tr_y, w.c.tr_y);
        check("cmt_bl_x", cmt_bl_x, w.c.bl_x); check("cmt_bl_y", cmt_bl_y, w.c.bl_y);
        check("cmt_br_x", cmt_br_x, w.c.br_x); check("cmt_br_y", cmt_br_y, w.c.br_y);
        check("scale", scale, w.sc);
        check("overlay_en_commit", overlay_en, 1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input corners_t c, input int cnt, input bit retrig);
    int lat, p0;
    bit valid;
    valid = (cnt >= 200);
    lat = -1;
    p0 = pulses;
    live = c; color_count = 19'(cnt); VGA_Y = 11'd480; VGA_X = 11'd0;
    model_frame(c, cnt);
    tick();
    // Live inputs change mid-frame; a re-capture would commit this garbage.
    VGA_X = 11'd1; VGA_Y = 11'd200; live = corners_t'(~c); color_count = 19'd5000;
    for (int k = 1; k <= 10; k++) begin
      VGA_X = (retrig && k == 2) ? 11'd0 : 11'd1;
      VGA_Y = (retrig && k == 2) ? 11'd480 : 11'd200;
      tick();
      if (params_updated === 1'b1 && lat < 0) lat = k;
    end
    check("latency", lat, valid ? 5 : -1);
    check("pulse_count", pulses - p0, valid ? 1 : 0);
    check("sb_drained", sb.size(), 0);
    check("overlay_en", overlay_en, m_en);
    check("scale_held", scale, m_scale);
    check("cmt_tl_x_held", cmt_tl_x, m_c.tl_x);
    check("cmt_br_y_held", cmt_br_y, m_c.br_y);
    check("busy_idle", busy, 0);
  endtask

  initial begin
    int p0;
    model_reset();
    reset = 1; VGA_X = 11'd5; VGA_Y = 11'd0; live = '0; color_count = '0;
    repeat (3) tick();
    check("rst_scale", scale, 2); check("rst_en", overlay_en, 0);
    check("rst_pu", params_updated, 0); check("rst_busy", busy, 0);
    check("rst_tl_x", cmt_tl_x, 0); check("rst_br_y", cmt_br_y, 0);
    reset = 0;
    tick();
    check("idle_busy", busy, 0);

    run_frame(mk(100, 100, 400, 100, 100, 300, 400, 300), 5000, 0);
    run_frame(mk(100, 100, 600, 100, 100, 300, 600, 300), 5000, 1);

    // Capture line off by one must be ignored.
    p0 = pulses;
    live = mk(1, 2, 3, 4, 5, 6, 7, 8); color_count = 19'd5000; VGA_Y = 11'd479; VGA_X = 11'd0;
    tick();
    VGA_X = 11'd1;
    check("y479_busy", busy, 0);
    repeat (8) tick();
    check("y479_pulses", pulses - p0, 0);
    check("y479_scale", scale, m_scale);

    for (int i = 0; i < 3; i++) run_frame(mk(50 + i, 60, 70, 80, 90, 100, 110, 120), 50, 0);
    run_frame(mk(100, 100, 400, 100, 100, 300, 400, 300), 200, 0);
    run_frame(mk(9, 9, 9, 9, 9, 9, 9, 9), 199, 0);
    run_frame(mk(500, 0, 20, 0, 1, 2, 3, 4), 5000, 0);
    run_frame(mk(20, 0, 499, 0, 1, 2, 3, 4), 5000, 0);
    run_frame(mk(200, 100, 210, 100, 7, 8, 9, 10), 5000, 0);
    run_frame(mk(105, 100, 100, 100, 7, 8, 9, 10), 5000, 0);
    run_frame(mk(0, 0, 0, 192, 11, 12, 13, 14), 5000, 0);
    run_frame(mk(0, 0, 0, 191, 11, 12, 13, 14), 5000, 0);

    // Reset while the FSM is in SQY discards the computation.
    p0 = pulses;
    live = mk(300, 300, 900, 300, 1, 1, 1, 1); color_count = 19'd5000; VGA_Y = 11'd480; VGA_X = 11'd0;
    tick();
    VGA_X = 11'd1;
    tick(); tick();
    check("sqy_busy", busy, 1);
    reset = 1;
    tick();
    check("rst_sqy_busy", busy, 0); check("rst_sqy_scale", scale, 2);
    check("rst_sqy_en", overlay_en, 0); check("rst_sqy_pu", params_updated, 0);
    check("rst_sqy_tl_x", cmt_tl_x, 0);
    reset = 0;
    sb.delete();
    model_reset();
    repeat (8) tick();
    check("rst_sqy_pulses", pulses - p0, 0);

    run_frame(mk(100, 100, 400, 100, 100, 300, 400, 300), 5000, 0);
    run_frame(mk(200, 100, 400, 100, 101, 300, 400, 301), 5000, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
